// File: rtl/matrix_pkg.sv
// Shared constants, op encodings and sequencer state type for the matrix operation sequencer.
package matrix_pkg;

    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DIM_W   = 3;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] OP_TRANSPOSE = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD       = 4'b0010;
    localparam logic [OP_W-1:0] OP_SCALAR    = 4'b0100;
    localparam logic [OP_W-1:0] OP_MUL       = 4'b1000;
    localparam logic [OP_W-1:0] OP_CONV      = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_ERR
    } seq_state_e;

    // A dimension is usable when it is non-zero and fits the storage.
    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_loop_counter.sv
// Three-level i/j/k nested loop counter with wrap flags and running row bases (idx*MAX_DIM).
module matrix_loop_counter
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DIM_W-1:0]  i_bound,
    input  logic [DIM_W-1:0]  j_bound,
    input  logic [DIM_W-1:0]  k_bound,
    output logic [DIM_W-1:0]  i_idx,
    output logic [DIM_W-1:0]  j_idx,
    output logic [DIM_W-1:0]  k_idx,
    output logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] j_base,
    output logic [ADDR_W-1:0] k_base,
    output logic              i_wrap_c,
    output logic              j_wrap_c,
    output logic              k_wrap_c
);

    assign i_wrap_c = (i_idx == i_bound - DIM_W'(1));
    assign j_wrap_c = (j_idx == j_bound - DIM_W'(1));
    assign k_wrap_c = (k_idx == k_bound - DIM_W'(1));

    // Innermost k advances every enabled cycle; bases step by the row stride.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            i_idx  <= '0;
            j_idx  <= '0;
            k_idx  <= '0;
            i_base <= '0;
            j_base <= '0;
            k_base <= '0;
        end else if (en) begin
            if (k_wrap_c) begin
                k_idx  <= '0;
                k_base <= '0;
                if (j_wrap_c) begin
                    j_idx  <= '0;
                    j_base <= '0;
                    if (i_wrap_c) begin
                        i_idx  <= '0;
                        i_base <= '0;
                    end else begin
                        i_idx  <= i_idx + DIM_W'(1);
                        i_base <= i_base + ADDR_W'(MAX_DIM);
                    end
                end else begin
                    j_idx  <= j_idx + DIM_W'(1);
                    j_base <= j_base + ADDR_W'(MAX_DIM);
                end
            end else begin
                k_idx  <= k_idx + DIM_W'(1);
                k_base <= k_base + ADDR_W'(MAX_DIM);
            end
        end
    end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequences transpose/add/scalar-mul/matrix-mul loops: operand reads, datapath qualifiers and result writes.
module matrix_op_sequencer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op_type,
    input  logic [DIM_W-1:0]  a_rows,
    input  logic [DIM_W-1:0]  a_cols,
    input  logic [DIM_W-1:0]  b_rows,
    input  logic [DIM_W-1:0]  b_cols,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              dp_valid,
    output logic              dp_first,
    output logic              dp_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready,
    output logic [DIM_W-1:0]  res_rows,
    output logic [DIM_W-1:0]  res_cols,
    output logic              busy,
    output logic              done,
    output logic              error
);

    seq_state_e       state_q, state_d;
    logic [OP_W-1:0]  op_q;
    logic [DIM_W-1:0] a_rows_q, a_cols_q, b_rows_q, b_cols_q;

    logic [DIM_W-1:0]  i_idx, j_idx, k_idx;
    logic [ADDR_W-1:0] i_base, j_base, k_base;
    logic              i_wrap_c, j_wrap_c, k_wrap_c;
    logic              cnt_clr_c;
    logic              stall_c, issue_c, legal_c, last_term_c;
    logic              is_mul_c, is_tr_c;
    logic [ADDR_W-1:0] wr_addr_next_c;

    assign is_mul_c    = (op_q == OP_MUL);
    assign is_tr_c     = (op_q == OP_TRANSPOSE);
    assign stall_c     = wr_en && !wr_ready;
    assign issue_c     = (state_q == ST_RUN) && !stall_c;
    assign last_term_c = i_wrap_c && j_wrap_c && k_wrap_c;

    // Read strobe must drop in the same cycle a pending write is refused.
    assign rd_en = issue_c;

    // Element-wise ops run k over a single term so first/last coincide.
    matrix_loop_counter u_loop (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr_c),
        .en       (issue_c),
        .i_bound  (a_rows_q),
        .j_bound  (is_mul_c ? b_cols_q : a_cols_q),
        .k_bound  (is_mul_c ? a_cols_q : DIM_W'(1)),
        .i_idx    (i_idx),
        .j_idx    (j_idx),
        .k_idx    (k_idx),
        .i_base   (i_base),
        .j_base   (j_base),
        .k_base   (k_base),
        .i_wrap_c (i_wrap_c),
        .j_wrap_c (j_wrap_c),
        .k_wrap_c (k_wrap_c)
    );

    assign rd_addr_a      = i_base + ADDR_W'(is_mul_c ? k_idx : j_idx);
    assign rd_addr_b      = (is_mul_c ? k_base : i_base) + ADDR_W'(j_idx);
    assign wr_addr_next_c = is_tr_c ? (j_base + ADDR_W'(i_idx)) : (i_base + ADDR_W'(j_idx));

    // Operation legality on the latched operands.
    always_comb begin
        logic dims_ok;
        dims_ok = dim_ok(a_rows_q) && dim_ok(a_cols_q) && dim_ok(b_rows_q) && dim_ok(b_cols_q);
        legal_c = 1'b0;
        case (op_q)
            OP_TRANSPOSE: legal_c = dims_ok;
            OP_SCALAR:    legal_c = dims_ok;
            OP_ADD:       legal_c = dims_ok && (a_rows_q == b_rows_q) && (a_cols_q == b_cols_q);
            OP_MUL:       legal_c = dims_ok && (a_cols_q == b_rows_q);
            OP_CONV:      legal_c = 1'b0;
            default:      legal_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr_c = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: begin
                cnt_clr_c = 1'b1;
                state_d   = legal_c ? ST_RUN : ST_ERR;
            end
            ST_RUN:   if (issue_c && last_term_c) state_d = ST_DRAIN;
            ST_DRAIN: if (wr_en && wr_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            busy  <= (state_d != ST_IDLE);
            done  <= (state_d == ST_DONE);
            error <= (state_d == ST_ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_rows_q <= '0;
            a_cols_q <= '0;
            b_rows_q <= '0;
            b_cols_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            op_q     <= op_type;
            a_rows_q <= a_rows;
            a_cols_q <= a_cols;
            b_rows_q <= b_rows;
            b_cols_q <= b_cols;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_rows <= '0;
            res_cols <= '0;
        end else if (state_q == ST_CHECK && legal_c) begin
            res_rows <= is_tr_c ? a_cols_q : a_rows_q;
            res_cols <= is_tr_c ? a_rows_q : (is_mul_c ? b_cols_q : a_cols_q);
        end
    end

    // Datapath qualifier stage: one cycle behind the read, frozen while a write is refused.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_first <= 1'b0;
            dp_last  <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
        end else if (!stall_c) begin
            dp_valid <= issue_c;
            dp_first <= issue_c && (k_idx == '0);
            dp_last  <= issue_c && k_wrap_c;
            wr_en    <= issue_c && k_wrap_c;
            if (issue_c) wr_addr <= wr_addr_next_c;
        end
    end

endmodule
